quad_speed_meter: RTL and testbench

Multi-channel quadrature speed meter for the motor-feedback path. It samples NUM_CH quadrature encoder pairs (A/B) with x4 decoding. Over a fixed gate window it accumulates a signed step count per channel, then publishes all channels together with a one-cycle valid strobe. It adds direction, per-channel saturation and illegal-transition detection, which the single-channel unsigned pulse counter does not provide.

---
 rtl/quad_pkg.sv | 25 ++
 rtl/quad_channel.sv | 96 +++++++++
 rtl/quad_speed_meter.sv | 70 +++++++
 tb/tb_quad_speed_meter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and the quadrature transition decoder for the speed meter.
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    localparam int unsigned INHIBIT_CYCLES = 3;

    // {A,B} pairs: forward walks 00 -> 10 -> 11 -> 01 -> 00
    function automatic step_t quad_decode(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_t s;
        case ({prev_ab, cur_ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: s = STEP_ERR;
            default:                                 s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchronizer, history, x4 decode, saturating
// windowed accumulator with sticky sat/err flags and latched results.
module quad_channel
    import quad_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    dec_en,
    input  logic                    tc,
    input  logic                    clr,
    output logic signed [CNT_W-1:0] speed,
    output logic                    sat,
    output logic                    err
);

    localparam logic signed [CNT_W:0]   LIMIT     = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0]   NEG_LIMIT = -LIMIT;
    localparam logic signed [CNT_W:0]   ONE       = (CNT_W+1)'(1);
    localparam logic signed [CNT_W-1:0] MAX_CNT   = LIMIT[CNT_W-1:0];
    localparam logic signed [CNT_W-1:0] MIN_CNT   = NEG_LIMIT[CNT_W-1:0];

    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] hist;

    logic signed [CNT_W-1:0] acc;
    logic signed [CNT_W-1:0] acc_next;
    logic signed [CNT_W:0]   sum;
    logic                    clip;
    logic                    win_sat;
    logic                    win_err;
    step_t                   step;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_comb begin
        step = dec_en ? quad_decode(hist, sync2) : STEP_NONE;
        sum  = {acc[CNT_W-1], acc};
        if (step == STEP_FWD) begin
            sum = sum + ONE;
        end else if (step == STEP_REV) begin
            sum = sum - ONE;
        end
        clip     = 1'b0;
        acc_next = sum[CNT_W-1:0];
        if (sum > LIMIT) begin
            acc_next = MAX_CNT;
            clip     = 1'b1;
        end else if (sum < NEG_LIMIT) begin
            acc_next = MIN_CNT;
            clip     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            win_sat <= 1'b0;
            win_err <= 1'b0;
            speed   <= '0;
            sat     <= 1'b0;
            err     <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            win_sat <= 1'b0;
            win_err <= 1'b0;
        end else if (tc) begin
            // the terminal-cycle step is folded into the published window
            speed   <= acc_next;
            sat     <= win_sat | clip;
            err     <= win_err | (step == STEP_ERR);
            acc     <= '0;
            win_sat <= 1'b0;
            win_err <= 1'b0;
        end else begin
            acc     <= acc_next;
            win_sat <= win_sat | clip;
            win_err <= win_err | (step == STEP_ERR);
        end
    end

endmodule

// File: rtl/quad_speed_meter.sv
// Multi-channel quadrature speed meter: shared gate window, decode inhibit
// and valid strobe around NUM_CH quad_channel instances.
module quad_speed_meter
    import quad_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned WINDOW = 60000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       enc_a,
    input  logic [NUM_CH-1:0]       enc_b,
    output logic [NUM_CH*CNT_W-1:0] speed,
    output logic [NUM_CH-1:0]       sat,
    output logic [NUM_CH-1:0]       err,
    output logic                    valid
);

    localparam int unsigned     WIN_W = $clog2(WINDOW);
    localparam int unsigned     INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [WIN_W-1:0] LAST = WIN_W'(WINDOW - 1);

    logic [WIN_W-1:0] win_cnt;
    logic [INH_W-1:0] inh_cnt;
    logic             tc;
    logic             dec_en;

    assign tc     = enable && (win_cnt == LAST);
    assign dec_en = enable && (inh_cnt == '0);

    // inhibit reloads whenever the gate is closed, masking stale sync data
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt <= '0;
            inh_cnt <= INH_W'(INHIBIT_CYCLES);
            valid   <= 1'b0;
        end else begin
            valid <= tc;
            if (!enable) begin
                win_cnt <= '0;
                inh_cnt <= INH_W'(INHIBIT_CYCLES);
            end else begin
                win_cnt <= tc ? '0 : win_cnt + WIN_W'(1);
                if (inh_cnt != '0) begin
                    inh_cnt <= inh_cnt - INH_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        quad_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .enc_a (enc_a[i]),
            .enc_b (enc_b[i]),
            .dec_en(dec_en),
            .tc    (tc),
            .clr   (!enable),
            .speed (speed[i*CNT_W +: CNT_W]),
            .sat   (sat[i]),
            .err   (err[i])
        );
    end

endmodule

// File: tb/tb_quad_speed_meter.sv
// Bench for quad_speed_meter: directed window table, boundary/reset/enable
// sequences and randomized encoder traffic against an event-level model.
module tb_quad_speed_meter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [1:0]  enc_a;
    logic [1:0]  enc_b;
    logic [15:0] speed0;
    logic [1:0]  sat0;
    logic [1:0]  err0;
    logic        valid0;
    logic [15:0] speed1;
    logic [1:0]  sat1;
    logic [1:0]  err1;
    logic        valid1;

    quad_speed_meter #(.NUM_CH(2), .CNT_W(8), .WINDOW(100)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed0), .sat(sat0), .err(err0), .valid(valid0)
    );

    quad_speed_meter #(.NUM_CH(2), .CNT_W(8), .WINDOW(400)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .enc_a(enc_a), .enc_b(enc_b),
        .speed(speed1), .sat(sat1), .err(err1), .valid(valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int edge_idx;
        int ch;
        int code;
    } ev_t;

    typedef struct {
        int         n0;
        int         n1;
        bit         inj_err;
        int         exp_s0;
        int         exp_s1;
        logic [1:0] exp_sat;
        logic [1:0] exp_err;
    } vec_t;

    localparam int WIN [2] = '{100, 400};
    localparam int LIM     = 127;

    int         checks;
    int         errors;
    int         edge_cnt;
    ev_t        evq [$];
    logic [1:0] ab_st [2];

    int m_cnt   [2];
    int m_inh   [2];
    bit m_valid [2];
    int m_acc   [2][2];
    bit m_wsat  [2][2];
    bit m_werr  [2][2];
    int m_speed [2][2];
    bit m_sat   [2][2];
    bit m_err   [2][2];

    function automatic int pos_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_vec(input string name, input logic [20:0] got, input logic [20:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (edge %0d)", name, got, want, edge_cnt);
        end
    endtask

    // Reference: each pin change becomes an event decoded two edges after sampling.
    task automatic model_edge();
        int a;
        edge_cnt++;
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_cnt[m]   = 0;
                m_inh[m]   = 3;
                m_valid[m] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_acc[m][c] = 0; m_wsat[m][c] = 0; m_werr[m][c] = 0;
                    m_speed[m][c] = 0; m_sat[m][c] = 0; m_err[m][c] = 0;
                end
            end else if (!enable) begin
                m_cnt[m]   = 0;
                m_inh[m]   = 3;
                m_valid[m] = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    m_acc[m][c] = 0; m_wsat[m][c] = 0; m_werr[m][c] = 0;
                end
            end else begin
                foreach (evq[i]) begin
                    if (evq[i].edge_idx == edge_cnt && m_inh[m] == 0) begin
                        if (evq[i].code == 2) begin
                            m_werr[m][evq[i].ch] = 1'b1;
                        end else begin
                            a = m_acc[m][evq[i].ch] + evq[i].code;
                            if (a > LIM)  begin a = LIM;  m_wsat[m][evq[i].ch] = 1'b1; end
                            if (a < -LIM) begin a = -LIM; m_wsat[m][evq[i].ch] = 1'b1; end
                            m_acc[m][evq[i].ch] = a;
                        end
                    end
                end
                m_valid[m] = (m_cnt[m] == WIN[m] - 1);
                if (m_valid[m]) begin
                    for (int c = 0; c < 2; c++) begin
                        m_speed[m][c] = m_acc[m][c];
                        m_sat[m][c]   = m_wsat[m][c];
                        m_err[m][c]   = m_werr[m][c];
                        m_acc[m][c] = 0; m_wsat[m][c] = 0; m_werr[m][c] = 0;
                    end
                end
                m_cnt[m] = (m_cnt[m] + 1) % WIN[m];
                if (m_inh[m] > 0) m_inh[m]--;
            end
        end
        while (evq.size() > 0 && evq[0].edge_idx <= edge_cnt) evq.delete(0);
    endtask

    task automatic compare_model();
        logic [20:0] want;
        want = {m_valid[0], m_sat[0][1], m_sat[0][0], m_err[0][1], m_err[0][0],
                8'(m_speed[0][1]), 8'(m_speed[0][0])};
        check_vec("model_w100", {valid0, sat0, err0, speed0}, want);
        want = {m_valid[1], m_sat[1][1], m_sat[1][0], m_err[1][1], m_err[1][0],
                8'(m_speed[1][1]), 8'(m_speed[1][0])};
        check_vec("model_w400", {valid1, sat1, err1, speed1}, want);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    // kind: 1 forward, -1 reverse, 2 illegal (both bits flip)
    task automatic drive(input int ch, input int kind);
        logic [1:0] nxt;
        int         d;
        ev_t        ev;
        if (kind == 2) nxt = ab_st[ch] ^ 2'b11;
        else           nxt = ab_of(pos_of(ab_st[ch]) + ((kind > 0) ? 1 : 3));
        d           = (pos_of(nxt) - pos_of(ab_st[ch]) + 4) % 4;
        ev.edge_idx = edge_cnt + 3;
        ev.ch       = ch;
        ev.code     = (d == 1) ? 1 : (d == 3) ? -1 : 2;
        evq.push_back(ev);
        ab_st[ch] = nxt;
        enc_a[ch] = nxt[1];
        enc_b[ch] = nxt[0];
    endtask

    task automatic wait_valid(input int which, input int max_cyc, output int n);
        n = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            tick();
            if (((which == 0) ? valid0 : valid1) == 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL wait_valid%0d got no valid want one within %0d cycles", which, max_cyc);
        end
    endtask

    initial begin
        vec_t vecs [4];
        int   n;
        int   steps;
        int   a0;
        int   a1;
        int   nxt [2];
        int   off;
        int   r;

        vecs[0] = '{10, -7, 1'b0, 10, -7, 2'b00, 2'b00};
        vecs[1] = '{-3,  4, 1'b0, -3,  4, 2'b00, 2'b00};
        vecs[2] = '{ 5,  0, 1'b1,  5,  0, 2'b00, 2'b01};
        vecs[3] = '{ 0,  0, 1'b0,  0,  0, 2'b00, 2'b00};

        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        enc_a    = '0;
        enc_b    = '0;
        ab_st[0] = 2'b00;
        ab_st[1] = 2'b00;

        repeat (4) tick();
        check_int("rst_speed0", int'(speed0), 0);
        check_int("rst_flags0", int'({sat0, err0, valid0}), 0);
        check_int("rst_speed1", int'(speed1), 0);
        check_int("rst_flags1", int'({sat1, err1, valid1}), 0);

        reset  = 1'b0;
        enable = 1'b1;

        foreach (vecs[k]) begin
            repeat (5) tick();
            a0    = (vecs[k].n0 < 0) ? -vecs[k].n0 : vecs[k].n0;
            a1    = (vecs[k].n1 < 0) ? -vecs[k].n1 : vecs[k].n1;
            steps = (a0 > a1) ? a0 : a1;
            for (int i = 0; i < steps; i++) begin
                if (i < a0) drive(0, (vecs[k].n0 > 0) ? 1 : -1);
                if (i < a1) drive(1, (vecs[k].n1 > 0) ? 1 : -1);
                repeat (5) tick();
            end
            if (vecs[k].inj_err) begin
                drive(0, 2);
                repeat (5) tick();
            end
            wait_valid(0, 200, n);
            check_int($sformatf("vec%0d_s0", k), s8(speed0[7:0]), vecs[k].exp_s0);
            check_int($sformatf("vec%0d_s1", k), s8(speed0[15:8]), vecs[k].exp_s1);
            check_int($sformatf("vec%0d_sat", k), int'(sat0), int'(vecs[k].exp_sat));
            check_int($sformatf("vec%0d_err", k), int'(err0), int'(vecs[k].exp_err));
        end

        // saturation on the 400-cycle instance
        wait_valid(1, 450, n);
        for (int i = 0; i < 130; i++) begin
            drive(0, 1);
            repeat (3) tick();
        end
        wait_valid(1, 100, n);
        check_int("sat_s0", s8(speed1[7:0]), 127);
        check_int("sat_s1", s8(speed1[15:8]), 0);
        check_int("sat_flag", int'(sat1), 1);
        wait_valid(1, 450, n);
        check_int("sat_quiet_s0", s8(speed1[7:0]), 0);
        check_int("sat_quiet_flag", int'(sat1), 0);

        // terminal-count boundary on the 100-cycle instance
        wait_valid(0, 150, n);
        repeat (97) tick();
        drive(0, 1);
        tick();
        drive(0, 1);
        wait_valid(0, 150, n);
        check_int("bnd_close_n", n, 2);
        check_int("bnd_close_s0", s8(speed0[7:0]), 1);
        wait_valid(0, 150, n);
        check_int("bnd_next_n", n, 100);
        check_int("bnd_next_s0", s8(speed0[7:0]), 1);

        // reset mid-window
        for (int i = 0; i < 4; i++) begin
            drive(0, 1);
            repeat (5) tick();
        end
        repeat (30) tick();
        reset = 1'b1;
        tick();
        check_int("mid_rst_speed0", int'(speed0), 0);
        check_int("mid_rst_flags0", int'({sat0, err0, valid0}), 0);
        repeat (2) begin
            tick();
            check_int("mid_rst_valid", int'(valid0), 0);
        end
        reset = 1'b0;
        wait_valid(0, 150, n);
        check_int("rst_release_latency", n, 100);

        // enable low holds results
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1);
            repeat (5) tick();
        end
        wait_valid(0, 150, n);
        check_int("en_pre_s0", s8(speed0[7:0]), 3);
        enable = 1'b0;
        repeat (30) begin
            tick();
            check_int("en_low_valid", int'(valid0), 0);
        end
        check_int("en_low_hold_s0", s8(speed0[7:0]), 3);
        enable = 1'b1;
        wait_valid(0, 150, n);
        check_int("en_rise_latency", n, 100);

        // randomized traffic, including illegal steps, gate drops and a reset
        nxt[0] = 3;
        nxt[1] = 4;
        off    = 0;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (t == 1500) reset = 1'b1;
            if (t == 1502) reset = 1'b0;
            if (off > 0) begin
                off--;
                if (off == 0) enable = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                enable = 1'b0;
                off    = $urandom_range(5, 20);
            end
            for (int c = 0; c < 2; c++) begin
                if (nxt[c] == 0) begin
                    r = $urandom_range(0, 9);
                    drive(c, (r < 5) ? 1 : (r < 9) ? -1 : 2);
                    nxt[c] = $urandom_range(3, 8);
                end else begin
                    nxt[c]--;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
